// File: rtl/mc_mem_fetch_unit_if.sv
// Controller <-> memory/fetch unit bus: control strobes and operands in,
// fetched instruction, loaded data and PC state out.
interface mc_mem_fetch_unit_if;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [31:0] Result;
  logic [31:0] ALUOut;
  logic [31:0] WriteData;
  logic [31:0] PC;
  logic [31:0] Adr;
  logic [31:0] ReadData;
  logic [31:0] Instr;
  logic [31:0] Data;
  logic        addr_fault;

  modport master (
    output PCWrite, AdrSrc, MemWrite, IRWrite, Result, ALUOut, WriteData,
    input  PC, Adr, ReadData, Instr, Data, addr_fault
  );

  modport slave (
    input  PCWrite, AdrSrc, MemWrite, IRWrite, Result, ALUOut, WriteData,
    output PC, Adr, ReadData, Instr, Data, addr_fault
  );
endinterface

// File: rtl/mc_mem_fetch_unit.sv
// Memory-side responder of the multicycle core: PC, unified word-addressed
// memory, instruction and data registers, bench preload port, sticky fault flag.
module mc_mem_fetch_unit #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_mem_fetch_unit_if.slave   bus,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [31:0]          load_data
);

  logic [31:0] mem [DEPTH];

  logic [31:0] pcQ, pcD;
  logic [31:0] instrQ, instrD;
  logic [31:0] dataQ;
  logic        faultQ, faultD;

  logic [31:0]   adr;
  logic [AW-1:0] wordIdx;
  logic [31:0]   readData;
  logic          accessActive;
  logic          highBitsSet;
  logic          accessBad;

  assign adr          = bus.AdrSrc ? bus.ALUOut : pcQ;
  assign wordIdx      = adr[AW+1:2];
  assign readData     = mem[wordIdx];
  assign accessActive = bus.MemWrite | bus.IRWrite | bus.AdrSrc;
  // Anything above the index range is an out-of-range access, not an alias.
  assign highBitsSet  = |(adr >> (AW + 2));
  assign accessBad    = accessActive & ((adr[1:0] != 2'b00) | highBitsSet);

  always_comb begin
    pcD    = pcQ;
    instrD = instrQ;
    faultD = faultQ;
    if (bus.PCWrite) begin
      pcD = bus.Result;
    end
    if (bus.IRWrite && !accessBad) begin
      instrD = readData;
    end
    if (accessBad) begin
      faultD = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcQ    <= 32'h0;
      instrQ <= 32'h0;
      dataQ  <= 32'h0;
      faultQ <= 1'b0;
    end else begin
      pcQ    <= pcD;
      instrQ <= instrD;
      dataQ  <= readData;
      faultQ <= faultD;
    end
  end

  // Preload wins over a store and works regardless of reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (reset && bus.MemWrite && !accessBad) begin
      mem[wordIdx] <= bus.WriteData;
    end
  end

  assign bus.PC         = pcQ;
  assign bus.Adr        = adr;
  assign bus.ReadData   = readData;
  assign bus.Instr      = instrQ;
  assign bus.Data       = dataQ;
  assign bus.addr_fault = faultQ;

endmodule

// File: tb/tb_mc_mem_fetch_unit.sv
// Scoreboard bench for mc_mem_fetch_unit: stimulus queues expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_mc_mem_fetch_unit;

  localparam int SigPc    = 0;
  localparam int SigInstr = 1;
  localparam int SigData  = 2;
  localparam int SigRd    = 3;
  localparam int SigFault = 4;
  localparam int SigAdr   = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  int          cyc = 0;
  int          nTests = 0;
  int          nFail = 0;
  exp_t        sb[$];

  mc_mem_fetch_unit_if bus ();

  mc_mem_fetch_unit #(
    .DEPTH (64),
    .AW    (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      SigPc:    return bus.PC;
      SigInstr: return bus.Instr;
      SigData:  return bus.Data;
      SigRd:    return bus.ReadData;
      SigFault: return {31'h0, bus.addr_fault};
      default:  return bus.Adr;
    endcase
  endfunction

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual(e.sig);
      nTests++;
      if (act !== e.exp || e.cyc != cyc) begin
        nFail++;
        $display("FAIL %s: got %08h, expected %08h (cycle %0d, due %0d)",
                 e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic expect_at(input int delay, input int sig, input logic [31:0] val,
                           input string name);
    exp_t e;
    e.cyc  = cyc + delay;
    e.sig  = sig;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge, then clear strobes.
  task automatic tick();
    @(posedge clk);
    #2;
    bus.PCWrite   = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    load_en       = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, queue=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    bus.PCWrite   = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.Result    = '0;
    bus.ALUOut    = '0;
    bus.WriteData = '0;

    // Preload program during reset
    tick(); preload(6'd0, 32'hE04F000F);
    tick(); preload(6'd1, 32'hE2802005);
    tick(); preload(6'd2, 32'hE2412003);
    tick();
    reset = 1'b1;
    expect_at(0, SigPc,    32'h0,        "reset_pc");
    expect_at(0, SigInstr, 32'h0,        "reset_instr");
    expect_at(0, SigData,  32'h0,        "reset_data");
    expect_at(0, SigFault, 32'h0,        "reset_fault");
    expect_at(0, SigRd,    32'hE04F000F, "reset_readdata");

    // Fetch 1
    tick();
    bus.IRWrite = 1'b1; bus.PCWrite = 1'b1; bus.Result = 32'h4;
    expect_at(1, SigInstr, 32'hE04F000F, "fetch1_instr");
    expect_at(1, SigPc,    32'h4,        "fetch1_pc");
    expect_at(1, SigData,  32'hE04F000F, "fetch1_data");

    // Fetch 2
    tick();
    bus.IRWrite = 1'b1; bus.PCWrite = 1'b1; bus.Result = 32'h8;
    expect_at(0, SigRd,    32'hE2802005, "fetch2_readdata");
    expect_at(1, SigInstr, 32'hE2802005, "fetch2_instr");
    expect_at(1, SigPc,    32'h8,        "fetch2_pc");

    // Store AB to 0x40 (word 16)
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h40; bus.WriteData = 32'hAB; bus.MemWrite = 1'b1;
    expect_at(0, SigAdr, 32'h40, "store_adr");
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h40;
    expect_at(0, SigRd,    32'hAB, "store_readback");
    expect_at(1, SigData,  32'hAB, "load_data");
    expect_at(1, SigFault, 32'h0,  "store_nofault");

    // Same-word read/write
    tick(); preload(6'd3, 32'h11);
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h0C; bus.MemWrite = 1'b1; bus.IRWrite = 1'b1;
    bus.WriteData = 32'h22;
    expect_at(0, SigRd,    32'h11, "rw_old_readdata");
    expect_at(1, SigInstr, 32'h11, "rw_instr_old");
    expect_at(1, SigData,  32'h11, "rw_data_old");
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h0C;
    expect_at(0, SigRd, 32'h22, "rw_new_readdata");

    // Preload beats a store to the same word
    tick(); preload(6'd3, 32'h33);
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h0C; bus.MemWrite = 1'b1; bus.WriteData = 32'h44;
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h0C;
    expect_at(0, SigRd,    32'h33, "preload_priority");
    expect_at(0, SigFault, 32'h0,  "preload_nofault");

    // Misaligned store
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h41; bus.MemWrite = 1'b1; bus.WriteData = 32'h99;
    expect_at(1, SigFault, 32'h1, "misalign_fault");
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h40;
    expect_at(0, SigRd,    32'hAB, "misalign_mem_kept");
    expect_at(1, SigFault, 32'h1,  "fault_sticky");

    // Out-of-range fetch
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h100; bus.IRWrite = 1'b1;
    expect_at(1, SigInstr, 32'h11, "range_instr_kept");
    expect_at(1, SigFault, 32'h1,  "range_fault");

    // Reset pulse clears the flag
    tick();
    reset = 1'b0;
    expect_at(1, SigFault, 32'h0, "reset_clears_fault");
    tick();
    reset = 1'b1;

    // Reset mid-operation
    bus.IRWrite = 1'b1; bus.PCWrite = 1'b1; bus.Result = 32'h20;
    expect_at(1, SigPc,    32'h20,       "midop_pc_set");
    expect_at(1, SigInstr, 32'hE04F000F, "midop_instr_set");
    tick();
    reset = 1'b0;
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h40; bus.MemWrite = 1'b1; bus.WriteData = 32'h77;
    preload(6'd5, 32'h55);
    expect_at(1, SigPc,    32'h0, "midop_pc_clear");
    expect_at(1, SigInstr, 32'h0, "midop_instr_clear");
    tick();
    reset = 1'b1;
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h40;
    expect_at(0, SigRd, 32'hAB, "midop_store_suppressed");
    tick();
    bus.AdrSrc = 1'b1; bus.ALUOut = 32'h14;
    expect_at(0, SigRd, 32'h55, "midop_preload_done");
    tick();
    expect_at(0, SigFault, 32'h0, "final_nofault");
    expect_at(0, SigRd,    32'hE04F000F, "final_readdata_pc0");

    tick(); tick(); tick();
    nTests++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
